// File: rtl/stage_ex_if.sv
// Execute-stage bundle: decode task in, data-memory request/response, write-back out.
// Carries no state; timing is owned by stage_ex.
// Backpressure: ex_ready_o gates task_i, dmem_ready_i completes a memory request.
interface stage_ex_if #(
  parameter int REG_DATA_WIDTH = 16,
  parameter int REG_ADDR_WIDTH = 3
);

  // ALU operation requested by decode
  typedef struct packed {
    logic [REG_DATA_WIDTH-1:0] a;
    logic [REG_DATA_WIDTH-1:0] b;
    logic [2:0]                cmd;
  } alu_task_t;

  // Side information decode attaches for the memory and write-back phases
  typedef struct packed {
    logic                      mem_wr_en;
    logic [REG_DATA_WIDTH-1:0] mem_wr_data;
    logic [REG_ADDR_WIDTH-1:0] wb_reg_addr;
    logic                      wb_wr_en;
    logic                      wb_mem_data_sel;
  } id_res_t;

  typedef struct packed {
    alu_task_t alu_task;
    id_res_t   id_res;
  } ex_task_t;

  // decode -> execute
  ex_task_t                  task_i;
  logic                      ex_ready_o;

  // execute <-> data memory
  logic [REG_DATA_WIDTH-1:0] dmem_addr_o;
  logic [REG_DATA_WIDTH-1:0] dmem_wr_data_o;
  logic                      dmem_wr_en_o;
  logic                      dmem_rd_en_o;
  logic                      dmem_ready_i;
  logic [REG_DATA_WIDTH-1:0] dmem_rd_data_i;

  // execute -> register file
  logic                      wb_wr_en_o;
  logic [REG_ADDR_WIDTH-1:0] wb_reg_addr_o;
  logic [REG_DATA_WIDTH-1:0] wb_data_o;
  logic                      wb_zero_o;

  // Environment side: decode, data memory and register file
  modport master (
    output task_i,
    input  ex_ready_o,
    input  dmem_addr_o,
    input  dmem_wr_data_o,
    input  dmem_wr_en_o,
    input  dmem_rd_en_o,
    output dmem_ready_i,
    output dmem_rd_data_i,
    input  wb_wr_en_o,
    input  wb_reg_addr_o,
    input  wb_data_o,
    input  wb_zero_o
  );

  // The execute stage itself
  modport slave (
    input  task_i,
    output ex_ready_o,
    output dmem_addr_o,
    output dmem_wr_data_o,
    output dmem_wr_en_o,
    output dmem_rd_en_o,
    input  dmem_ready_i,
    input  dmem_rd_data_i,
    output wb_wr_en_o,
    output wb_reg_addr_o,
    output wb_data_o,
    output wb_zero_o
  );

endinterface

// File: rtl/stage_ex.sv
// Execute stage: combinational ALU, then either register write-back or one data-memory access.
// Latency: ALU ops write back 1 cycle after accept; loads/stores hold the stage until dmem_ready_i.
// Backpressure: ex_ready_o is low for every MEM cycle; task_i is ignored while low.
module stage_ex #(
  parameter int REG_DATA_WIDTH = 16,
  parameter int REG_ADDR_WIDTH = 3
) (
  input logic       clk_i,
  input logic       rst_n_i,
  stage_ex_if.slave bus
);

  // ALU command encoding shared with decode
  localparam logic [2:0] ALU_NOP = 3'd0;
  localparam logic [2:0] ALU_ADD = 3'd1;
  localparam logic [2:0] ALU_SUB = 3'd2;
  localparam logic [2:0] ALU_AND = 3'd3;
  localparam logic [2:0] ALU_OR  = 3'd4;
  localparam logic [2:0] ALU_XOR = 3'd5;

  typedef enum logic {
    IDLE = 1'b0,
    MEM  = 1'b1
  } state_t;

  state_t                    state_q;

  // Memory request registers, held steady for the whole MEM phase
  logic [REG_DATA_WIDTH-1:0] dmem_addr_q;
  logic [REG_DATA_WIDTH-1:0] dmem_wr_data_q;
  logic                      dmem_wr_en_q;
  logic                      dmem_rd_en_q;

  // Write-back fields captured at accept for a pending load
  logic [REG_ADDR_WIDTH-1:0] cap_reg_addr_q;
  logic                      cap_wr_en_q;

  // Write-back pulse registers
  logic                      wb_wr_en_q;
  logic [REG_ADDR_WIDTH-1:0] wb_reg_addr_q;
  logic [REG_DATA_WIDTH-1:0] wb_data_q;

  // Unpacked view of the incoming task
  logic [REG_DATA_WIDTH-1:0] op_a;
  logic [REG_DATA_WIDTH-1:0] op_b;
  logic [2:0]                op_cmd;
  logic                      t_mem_wr_en;
  logic [REG_DATA_WIDTH-1:0] t_mem_wr_data;
  logic [REG_ADDR_WIDTH-1:0] t_wb_reg_addr;
  logic                      t_wb_wr_en;
  logic                      t_wb_mem_data_sel;

  assign op_a              = bus.task_i.alu_task.a;
  assign op_b              = bus.task_i.alu_task.b;
  assign op_cmd            = bus.task_i.alu_task.cmd;
  assign t_mem_wr_en       = bus.task_i.id_res.mem_wr_en;
  assign t_mem_wr_data     = bus.task_i.id_res.mem_wr_data;
  assign t_wb_reg_addr     = bus.task_i.id_res.wb_reg_addr;
  assign t_wb_wr_en        = bus.task_i.id_res.wb_wr_en;
  assign t_wb_mem_data_sel = bus.task_i.id_res.wb_mem_data_sel;

  // Task classification; a store wins over a load when both flags are set
  logic is_store;
  logic is_bubble;
  logic is_load;

  assign is_store  = t_mem_wr_en;
  assign is_bubble = !t_mem_wr_en && !t_wb_wr_en;
  assign is_load   = !t_mem_wr_en && t_wb_mem_data_sel;

  logic [REG_DATA_WIDTH-1:0] alu_res;

  // ALU: wrap-around arithmetic and bitwise ops; NOP and unknown commands give zero
  always_comb begin
    alu_res = '0;
    case (op_cmd)
      ALU_ADD: alu_res = op_a + op_b;
      ALU_SUB: alu_res = op_a - op_b;
      ALU_AND: alu_res = op_a & op_b;
      ALU_OR:  alu_res = op_a | op_b;
      ALU_XOR: alu_res = op_a ^ op_b;
      ALU_NOP: alu_res = '0;
      default: alu_res = '0;
    endcase
  end

  // Control FSM with registered outputs; write-back fields default to zero so each task pulses once
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q        <= IDLE;
      dmem_addr_q    <= '0;
      dmem_wr_data_q <= '0;
      dmem_wr_en_q   <= 1'b0;
      dmem_rd_en_q   <= 1'b0;
      cap_reg_addr_q <= '0;
      cap_wr_en_q    <= 1'b0;
      wb_wr_en_q     <= 1'b0;
      wb_reg_addr_q  <= '0;
      wb_data_q      <= '0;
    end else begin
      wb_wr_en_q    <= 1'b0;
      wb_reg_addr_q <= '0;
      wb_data_q     <= '0;

      case (state_q)
        IDLE: begin
          if (is_store || (!is_bubble && is_load)) begin
            // Launch a memory access; write-back waits for completion
            dmem_addr_q    <= alu_res;
            dmem_wr_data_q <= t_mem_wr_data;
            dmem_wr_en_q   <= is_store;
            dmem_rd_en_q   <= !is_store;
            cap_reg_addr_q <= t_wb_reg_addr;
            cap_wr_en_q    <= t_wb_wr_en;
            state_q        <= MEM;
          end else if (!is_bubble) begin
            // Plain ALU op: write back on the next edge
            wb_wr_en_q    <= t_wb_wr_en;
            wb_reg_addr_q <= t_wb_reg_addr;
            wb_data_q     <= alu_res;
          end
        end

        MEM: begin
          // Hold the request until memory completes it
          if (bus.dmem_ready_i) begin
            if (dmem_rd_en_q) begin
              wb_wr_en_q    <= cap_wr_en_q;
              wb_reg_addr_q <= cap_reg_addr_q;
              wb_data_q     <= bus.dmem_rd_data_i;
            end
            dmem_addr_q    <= '0;
            dmem_wr_data_q <= '0;
            dmem_wr_en_q   <= 1'b0;
            dmem_rd_en_q   <= 1'b0;
            cap_reg_addr_q <= '0;
            cap_wr_en_q    <= 1'b0;
            state_q        <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.ex_ready_o     = (state_q == IDLE);
  assign bus.dmem_addr_o    = dmem_addr_q;
  assign bus.dmem_wr_data_o = dmem_wr_data_q;
  assign bus.dmem_wr_en_o   = dmem_wr_en_q;
  assign bus.dmem_rd_en_o   = dmem_rd_en_q;
  assign bus.wb_wr_en_o     = wb_wr_en_q;
  assign bus.wb_reg_addr_o  = wb_reg_addr_q;
  assign bus.wb_data_o      = wb_data_q;
  assign bus.wb_zero_o      = wb_wr_en_q && (wb_data_q == '0);

endmodule
